// File: rtl/hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_if
//   Bundle between the pipeline datapath and the hazard controller.
//
//   Pipeline -> controller (master drives, slave receives):
//     ifid_rs_i, ifid_rt_i, ifid_uses_rt_i : source operands of the IF/ID instr
//     idex_memread_i, idex_rt_i            : ID/EX load and its destination
//     idex_mdu_i                           : ID/EX holds a multi-cycle mult/div
//     branch_taken_i                       : EX/MEM branch resolved taken
//   Controller -> pipeline:
//     pc_write_o, ifid_write_o, idex_write_o      : load enables
//     ifid_flush_o, idex_flush_o, exmem_flush_o   : bubble insertion
//     state_o                                     : 0 = RUN, 1 = MDU_WAIT
//     stall_cnt_o                                 : saturating stall counter
// -----------------------------------------------------------------------------
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       ifid_rs_i;
    logic [4:0]       ifid_rt_i;
    logic             ifid_uses_rt_i;
    logic             idex_memread_i;
    logic [4:0]       idex_rt_i;
    logic             idex_mdu_i;
    logic             branch_taken_i;

    logic             pc_write_o;
    logic             ifid_write_o;
    logic             idex_write_o;
    logic             ifid_flush_o;
    logic             idex_flush_o;
    logic             exmem_flush_o;
    logic             state_o;
    logic [CNT_W-1:0] stall_cnt_o;

    // Pipeline side.
    modport master (
        output ifid_rs_i, ifid_rt_i, ifid_uses_rt_i,
               idex_memread_i, idex_rt_i, idex_mdu_i, branch_taken_i,
        input  pc_write_o, ifid_write_o, idex_write_o,
               ifid_flush_o, idex_flush_o, exmem_flush_o,
               state_o, stall_cnt_o
    );

    // Controller side.
    modport slave (
        input  ifid_rs_i, ifid_rt_i, ifid_uses_rt_i,
               idex_memread_i, idex_rt_i, idex_mdu_i, branch_taken_i,
        output pc_write_o, ifid_write_o, idex_write_o,
               ifid_flush_o, idex_flush_o, exmem_flush_o,
               state_o, stall_cnt_o
    );
endinterface

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Hazard controller for the five-stage pipeline. Resolves taken-branch
//   flushes, multi-cycle MDU stalls and load-use stalls (in that priority),
//   and counts stall cycles in a saturating performance counter.
//
//   Parameters:
//     MDU_LAT : total stall cycles for one MDU instruction in EX (2..15)
//     CNT_W   : width of the stall counter (must match the interface CNT_W)
//
//   Ports:
//     clk_i : clock, rising edge
//     rst_i : synchronous, active-high reset
//     bus   : hazard_ctrl_if.slave, pipeline observation and control signals
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    hazard_ctrl_if.slave bus
);

    typedef enum logic {
        RUN      = 1'b0,
        MDU_WAIT = 1'b1
    } state_t;

    // The detection cycle and the final wait cycle (cnt_q = 0) are both stall
    // cycles, so the wait counter starts two below the total latency.
    localparam logic [3:0] LP_WAIT_INIT = 4'(MDU_LAT - 2);

    state_t           r_state;
    logic [3:0]       r_cnt;
    logic             r_mdu_done;
    logic [CNT_W-1:0] r_stall_cnt;

    state_t           w_state_nxt;
    logic [3:0]       w_cnt_nxt;
    logic             w_mdu_done_nxt;

    logic             w_load_use;
    logic             w_mdu_start;
    logic             w_mdu_stall;
    logic             w_pc_write;

    assign w_load_use = bus.idex_memread_i
                     && (bus.idex_rt_i != 5'd0)
                     && ((bus.idex_rt_i == bus.ifid_rs_i)
                      || (bus.ifid_uses_rt_i && (bus.idex_rt_i == bus.ifid_rt_i)));

    // mdu_done_q masks the MDU instruction still sitting in ID/EX on the
    // release cycle so it is not detected a second time.
    assign w_mdu_start = (r_state == RUN) && bus.idex_mdu_i && !r_mdu_done;
    assign w_mdu_stall = w_mdu_start || (r_state == MDU_WAIT);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= RUN;
            r_cnt       <= 4'd0;
            r_mdu_done  <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_mdu_done <= w_mdu_done_nxt;
            if (!w_pc_write && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every signal gets a default before any branch; without it a path
    // that skips an assignment would infer a latch.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_mdu_done_nxt = 1'b0;   // a set flag lives for exactly one cycle

        if (bus.branch_taken_i) begin
            // The MDU instruction is younger than the branch: squash it.
            w_state_nxt = RUN;
            w_cnt_nxt   = 4'd0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_mdu_start) begin
                        w_state_nxt = MDU_WAIT;
                        w_cnt_nxt   = LP_WAIT_INIT;
                    end
                end
                MDU_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        w_state_nxt    = RUN;
                        w_mdu_done_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt - 4'd1;
                    end
                end
                default: begin
                    w_state_nxt = RUN;
                    w_cnt_nxt   = 4'd0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_pc_write        = 1'b1;
        bus.ifid_write_o  = 1'b1;
        bus.idex_write_o  = 1'b1;
        bus.ifid_flush_o  = 1'b0;
        bus.idex_flush_o  = 1'b0;
        bus.exmem_flush_o = 1'b0;

        if (rst_i) begin
            // Defaults only.
        end else if (bus.branch_taken_i) begin
            bus.ifid_flush_o  = 1'b1;
            bus.idex_flush_o  = 1'b1;
            bus.exmem_flush_o = 1'b1;
        end else if (w_mdu_stall) begin
            // Front end frozen; EX/MEM gets bubbles while the MDU runs. This
            // also hides any load-use match, which needs no extra action.
            w_pc_write        = 1'b0;
            bus.ifid_write_o  = 1'b0;
            bus.idex_write_o  = 1'b0;
            bus.exmem_flush_o = 1'b1;
        end else if (w_load_use) begin
            w_pc_write        = 1'b0;
            bus.ifid_write_o  = 1'b0;
            bus.idex_flush_o  = 1'b1;
        end
    end

    assign bus.pc_write_o  = w_pc_write;
    assign bus.state_o     = r_state;
    assign bus.stall_cnt_o = r_stall_cnt;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage CPU. It watches the IF/ID, ID/EX and EX/MEM stages and drives the write-enable and flush controls of the PC and the pipe registers. It resolves three hazards: load-use stalls, multi-cycle MDU (mult/div) stalls, and taken-branch flushes. It also keeps a saturating stall-cycle counter for performance measurement.

## Interface
- MDU_LAT, 4, total stall cycles for one MDU instruction in EX; legal range 2..15
- CNT_W, 16, width of the stall performance counter

- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  reset, synchronous, active-high
- ifid_rs_i  in  5  rs field of the instruction in IF/ID
- ifid_rt_i  in  5  rt field of the instruction in IF/ID
- ifid_uses_rt_i  in  1  IF/ID instruction reads rt as a source
- idex_memread_i  in  1  ID/EX instruction is a load
- idex_rt_i  in  5  destination rt of the ID/EX instruction
- idex_mdu_i  in  1  ID/EX instruction is a multi-cycle mult/div
- branch_taken_i  in  1  branch in EX/MEM resolved taken
- pc_write_o  out  1  PC load enable
- ifid_write_o  out  1  IF/ID load enable (0 = hold)
- idex_write_o  out  1  ID/EX load enable (0 = hold)
- ifid_flush_o  out  1  load zero (bubble) into IF/ID
- idex_flush_o  out  1  load zero (bubble) into ID/EX
- exmem_flush_o  out  1  load zero (bubble) into EX/MEM
- state_o  out  1  0 = RUN, 1 = MDU_WAIT
- stall_cnt_o  out  CNT_W  stall cycles since reset, saturating

## Operation
- Registered state: state_q, wait counter cnt_q (4 bits), mdu_done_q (1 bit), perf counter.
- All outputs except state_o and stall_cnt_o are combinational from state and inputs.
- Defaults: all write enables are 1 and all flushes are 0.
- Priority, highest first: reset, branch, MDU, load-use.
- Branch (any state, branch_taken_i = 1):
  - ifid_flush_o = idex_flush_o = exmem_flush_o = 1; pc_write_o = 1.
  - In MDU_WAIT, the younger MDU instruction is squashed: next state is RUN, cnt_q = 0, mdu_done_q = 0.
- MDU start (RUN, idex_mdu_i = 1, mdu_done_q = 0):
  - pc_write_o = ifid_write_o = idex_write_o = 0; exmem_flush_o = 1.
  - Next state is MDU_WAIT with cnt_q = MDU_LAT - 2.
- MDU_WAIT:
  - Drives the same stall outputs as MDU start.
  - If cnt_q = 0, next state is RUN and mdu_done_q is set to 1. Otherwise cnt_q decrements.
- mdu_done_q:
  - Cleared on every cycle it is 1.
  - While 1, it blocks MDU re-detection of the same held instruction, which is released that cycle.
- Load-use (RUN, no branch, no MDU start):
  - Detected when idex_memread_i = 1, idex_rt_i ≠ 0, and idex_rt_i matches ifid_rs_i, or matches ifid_rt_i with ifid_uses_rt_i = 1.
  - Response: pc_write_o = ifid_write_o = 0; idex_flush_o = 1.
  - Lasts one cycle; no state change.
- A stall cycle is any cycle with pc_write_o = 0. The perf counter increments on each stall cycle and saturates at all-ones.
- During the MDU stall, load-use detection is ignored because the MDU stall already freezes the front end.

## Timing
- Reset: while rst_i = 1, all write enables are 1 and all flushes are 0.
- First rising edge with rst_i = 1: state RUN, cnt_q = 0, mdu_done_q = 0, stall_cnt_o = 0.
- Reset asserted in MDU_WAIT aborts the wait on that edge.
- MDU: exactly MDU_LAT consecutive stall cycles, counting the detection cycle. The front end releases on cycle MDU_LAT + 1.
- Load-use: exactly one stall cycle. The dependent instruction re-evaluates the next cycle, when ID/EX holds a bubble.
- Branch: flush takes effect on the same edge the PC loads the target. There is no stall cycle, so the perf counter is unchanged.
- A branch on the last MDU_WAIT cycle also returns to RUN with mdu_done_q = 0.

## Test plan
- Reset with MDU_LAT = 4 and all inputs at 0:
  - state_o = 0, stall_cnt_o = 0.
  - pc/ifid/idex write = 1, all flushes = 0.
- Load-use with idex_memread_i = 1, idex_rt_i = 8, ifid_rs_i = 8:
  - One cycle with pc_write_o = 0, ifid_write_o = 0, idex_flush_o = 1; stall_cnt_o becomes 1.
  - Repeat with idex_rt_i = 0: no stall.
  - Repeat with a match on ifid_rt_i only and ifid_uses_rt_i = 0: no stall.
- MDU with idex_mdu_i held at 1:
  - Exactly 4 stall cycles with exmem_flush_o = 1, state_o = 1 for 3 cycles.
  - 5th cycle: all enables 1 and no re-trigger.
  - stall_cnt_o = 4.
- Branch on the 2nd MDU_WAIT cycle:
  - That cycle: all three flushes = 1, pc_write_o = 1.
  - Next cycle: state_o = 0.
  - stall_cnt_o advances by 2 in total (detection cycle and first wait cycle).
- Branch in the same cycle as a load-use match:
  - Flushes asserted, pc_write_o = 1, no stall counted.
- Saturation with CNT_W = 2:
  - After 5 load-use stalls, stall_cnt_o = 3.
  - rst_i pulse clears it to 0.
